// File: rtl/serial_byte_tx.sv
// serial_byte_tx: parallel-in, serial-out transmitter with a one-word holding
// buffer. Words are shifted out MSB-first, one bit per clock, and consecutive
// frames stream back-to-back with no idle cycle between them.
// Optional feature macro: PARITY_EN appends an even-parity bit to each frame.
module serial_byte_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             done,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
`ifdef PARITY_EN
    ST_SHIFT  = 2'b01,
    ST_PARITY = 2'b10
`else
    ST_SHIFT  = 2'b01
`endif
  } state_t;

  state_t            state_r;
  logic [WIDTH-1:0]  sr_r;
  logic [CW-1:0]     bit_cnt_r;
  logic              hold_full_r;
  logic [WIDTH-1:0]  hold_data_r;
`ifdef PARITY_EN
  logic              parity_r;
`endif

  logic              last_bit_s;
  logic              accept_s;
  logic              bypass_s;
  logic              load_s;
  logic [WIDTH-1:0]  load_data_s;

  // Even parity over a data word.
  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    even_parity = ^word;
  endfunction

  // The serial bit is always the MSB of the shift register; the register is
  // cleared whenever no frame bit is being driven, so idle output is 0.
  assign ser_out  = sr_r[WIDTH-1];
  assign in_ready = ~hold_full_r;

  // Decode last-bit cycle, accept, and where a new word enters the shifter.
  always_comb begin
    last_bit_s  = 1'b0;
    accept_s    = 1'b0;
    bypass_s    = 1'b0;
    load_s      = 1'b0;
    load_data_s = {WIDTH{1'b0}};
`ifdef PARITY_EN
    last_bit_s = (state_r == ST_PARITY);
`else
    last_bit_s = (state_r == ST_SHIFT) && (bit_cnt_r == CNT_LAST);
`endif
    accept_s = in_valid & ~hold_full_r;
    bypass_s = accept_s & ((state_r == ST_IDLE) | last_bit_s);
    if (last_bit_s && hold_full_r) begin
      load_s      = 1'b1;
      load_data_s = hold_data_r;
    end else if (bypass_s) begin
      load_s      = 1'b1;
      load_data_s = in_data;
    end else begin
      load_s      = 1'b0;
      load_data_s = {WIDTH{1'b0}};
    end
  end

  // Holding buffer: fills on an accept that cannot bypass, drains on refill.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full_r <= 1'b0;
      hold_data_r <= {WIDTH{1'b0}};
    end else if (accept_s && !bypass_s) begin
      hold_full_r <= 1'b1;
      hold_data_r <= in_data;
    end else if (last_bit_s && hold_full_r) begin
      hold_full_r <= 1'b0;
    end else begin
      hold_full_r <= hold_full_r;
    end
  end

  // Frame FSM, shifter, bit counter and registered strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      sr_r        <= {WIDTH{1'b0}};
      bit_cnt_r   <= {CW{1'b0}};
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
`ifdef PARITY_EN
      parity_r    <= 1'b0;
`endif
    end else begin
      frame_start <= 1'b0;
      done        <= 1'b0;
      if (load_s) begin
        state_r     <= ST_SHIFT;
        sr_r        <= load_data_s;
        bit_cnt_r   <= {CW{1'b0}};
        ser_valid   <= 1'b1;
        frame_start <= 1'b1;
        busy        <= 1'b1;
`ifdef PARITY_EN
        parity_r    <= even_parity(load_data_s);
`endif
      end else begin
        case (state_r)
          ST_SHIFT: begin
            if (bit_cnt_r == CNT_LAST) begin
`ifdef PARITY_EN
              state_r   <= ST_PARITY;
              sr_r      <= {parity_r, {(WIDTH-1){1'b0}}};
              ser_valid <= 1'b1;
              done      <= 1'b1;
              busy      <= 1'b1;
`else
              state_r   <= ST_IDLE;
              sr_r      <= {WIDTH{1'b0}};
              ser_valid <= 1'b0;
              busy      <= 1'b0;
`endif
            end else begin
              sr_r      <= {sr_r[WIDTH-2:0], 1'b0};
              bit_cnt_r <= bit_cnt_r + CNT_ONE;
              ser_valid <= 1'b1;
              busy      <= 1'b1;
`ifdef PARITY_EN
              done      <= 1'b0;
`else
              done      <= (bit_cnt_r == CNT_PENULT);
`endif
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            sr_r      <= {WIDTH{1'b0}};
            ser_valid <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_byte_tx.sv
// Self-checking bench for serial_byte_tx: a queue-based frame model predicts
// every output each cycle; directed scenarios pin exact bit streams.
module tb_serial_byte_tx;
  localparam int W = 8;
`ifdef PARITY_EN
  localparam int FL = W + 1;
  localparam logic [31:0] EXP_A5   = 32'h0000014A;
  localparam logic [31:0] EXP_07   = 32'h0000000F;
  localparam logic [31:0] EXP_B2B  = 32'h00020478;
  localparam logic [31:0] EXP_01   = 32'h00000003;
  localparam logic [31:0] EXP_LATE = 32'h0003C0AA;
`else
  localparam int FL = W;
  localparam logic [31:0] EXP_A5   = 32'h000000A5;
  localparam logic [31:0] EXP_07   = 32'h00000007;
  localparam logic [31:0] EXP_B2B  = 32'h0000813C;
  localparam logic [31:0] EXP_01   = 32'h00000001;
  localparam logic [31:0] EXP_LATE = 32'h0000F055;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         ser_out, ser_valid, frame_start, done, busy;

  serial_byte_tx #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .ser_out(ser_out), .ser_valid(ser_valid),
    .frame_start(frame_start), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: words in flight (current frame first, then held word) and the
  // index of the bit currently on the line within the current frame.
  logic [W-1:0] mq[$];
  int pos = 0;
  bit m_acc;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mq.delete();
        pos = 0;
      end else begin
        m_acc = in_valid && (mq.size() < 2);
        if (mq.size() > 0) begin
          pos++;
          if (pos == FL) begin
            void'(mq.pop_front());
            pos = 0;
          end
        end
        if (m_acc) mq.push_back(in_data);
      end
    end
  end

  function automatic logic model_bit();
    logic [W-1:0] w;
    if (mq.size() == 0) return 1'b0;
    w = mq[0];
    if (pos < W) return w[W-1-pos];
    return ^w;
  endfunction

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("ser_valid",   ser_valid,   mq.size() > 0);
      chk("ser_out",     ser_out,     model_bit());
      chk("frame_start", frame_start, (mq.size() > 0) && (pos == 0));
      chk("done",        done,        (mq.size() > 0) && (pos == FL - 1));
      chk("busy",        busy,        mq.size() > 0);
      chk("in_ready",    in_ready,    mq.size() < 2);
    end
  end

  // Stream capture for directed checks.
  bit cap_q[$];
  bit fs_q[$];
  bit dn_q[$];
  int cap_t[$];
  int done_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (ser_valid) begin
        cap_q.push_back(ser_out);
        fs_q.push_back(frame_start);
        dn_q.push_back(done);
        cap_t.push_back(cyc);
      end
      if (done) done_cnt++;
    end
  end

  task automatic clear_cap();
    cap_q.delete(); fs_q.delete(); dn_q.delete(); cap_t.delete();
    done_cnt = 0;
  endtask

  task automatic send(input logic [W-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", in_ready, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
    @(negedge clk);
  endtask

  task automatic check_stream(input string name, input logic [31:0] exp_bits, input int exp_len);
    logic [31:0] v = '0;
    chk({name, "_len"}, cap_q.size(), exp_len);
    foreach (cap_q[i]) v = {v[30:0], cap_q[i]};
    chk({name, "_bits"}, v, exp_bits);
    if (cap_q.size() > 0) chk({name, "_gap"}, cap_t[$] - cap_t[0], cap_q.size() - 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_ser_out", ser_out, 1'b0);
    chk("rst_ser_valid", ser_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_strobes", {frame_start, done}, 2'b00);

    // Single word 0xA5.
    clear_cap();
    send(8'hA5);
    in_valid = 1'b0;
    wait_idle();
    check_stream("a5", EXP_A5, FL);
    if (fs_q.size() == FL) begin
      chk("a5_fs_first", fs_q[0], 1'b1);
      chk("a5_done_last", dn_q[FL-1], 1'b1);
    end
    chk("a5_done_cnt", done_cnt, 1);

    // Word with odd data-bit count.
    clear_cap();
    send(8'h07);
    in_valid = 1'b0;
    wait_idle();
    check_stream("x07", EXP_07, FL);

    // Back-to-back: second word lands in the holding buffer.
    clear_cap();
    send(8'h81);
    in_data = 8'h3C;
    send(8'h3C);
    chk("b2b_hold_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    wait_idle();
    check_stream("b2b", EXP_B2B, 2 * FL);
    chk("b2b_done_cnt", done_cnt, 2);

    // Reset in the middle of a frame.
    clear_cap();
    send(8'hFF);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_ser_valid", ser_valid, 1'b0);
    chk("midrst_ser_out", ser_out, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_bits_seen", cap_q.size(), 3);
    chk("midrst_no_done", done_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    clear_cap();
    send(8'h01);
    in_valid = 1'b0;
    wait_idle();
    check_stream("after_rst", EXP_01, FL);

    // Accept on the last-bit cycle with the holding buffer empty.
    clear_cap();
    send(8'hF0);
    in_valid = 1'b0;
    repeat (FL - 1) @(negedge clk);
    chk("late_lastbit_done", done, 1'b1);
    chk("late_lastbit_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(negedge clk);
    in_valid = 1'b0;
    chk("late_fs", frame_start, 1'b1);
    chk("late_msb", {ser_valid, ser_out}, 2'b10);
    wait_idle();
    check_stream("late", EXP_LATE, 2 * FL);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #2;
      reset_n  = ($urandom_range(0, 399) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = W'($urandom);
    end
    #2;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
